// File: rtl/downstream_cancel_tracker_if.sv
// Request/result bundle for downstream_cancel_tracker: one valid/ready request channel
// plus the result strobe and status flags. The master side drives requests.
interface downstream_cancel_tracker_if #(
  parameter int unsigned CLIENT_W = 5,
  parameter int unsigned AMOUNT_W = 16,
  parameter int unsigned COUNT_W  = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          op;
  logic [CLIENT_W-1:0] client_id;
  logic [AMOUNT_W-1:0] amount;
  logic [COUNT_W-1:0]  limit;
  logic                rd_valid;
  logic [CLIENT_W-1:0] rd_client;
  logic [COUNT_W-1:0]  cancelled_orders;
  logic                over_limit;
  logic                init_busy;

  modport master (
    output in_valid, op, client_id, amount, limit,
    input  in_ready, rd_valid, rd_client, cancelled_orders, over_limit, init_busy
  );

  modport slave (
    input  in_valid, op, client_id, amount, limit,
    output in_ready, rd_valid, rd_client, cancelled_orders, over_limit, init_busy
  );
endinterface

// File: rtl/downstream_cancel_tracker.sv
// Per-client saturating cancelled-order counters held in a synchronous RAM, updated by a
// two-stage read-modify-write pipeline with same-client forwarding and a post-reset clear sweep.
module downstream_cancel_tracker #(
  parameter int unsigned CLIENT_W = 5,
  parameter int unsigned AMOUNT_W = 16,
  parameter int unsigned COUNT_W  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  downstream_cancel_tracker_if.slave     bus
);
  localparam int unsigned Depth = 2 ** CLIENT_W;

  localparam logic [1:0] OpAdd   = 2'b00;
  localparam logic [1:0] OpSub   = 2'b01;
  localparam logic [1:0] OpClear = 2'b10;
  localparam logic [1:0] OpRead  = 2'b11;

  typedef enum logic {StInit, StRun} state_e;

  state_e              state_q;
  logic [CLIENT_W-1:0] sweep_q;
  logic                in_ready_q;
  logic                init_busy_q;

  logic                s1_valid_q;
  logic [1:0]          s1_op_q;
  logic [CLIENT_W-1:0] s1_client_q;
  logic [AMOUNT_W-1:0] s1_amount_q;
  logic [COUNT_W-1:0]  s1_limit_q;

  logic                rd_valid_q;
  logic [CLIENT_W-1:0] rd_client_q;
  logic [COUNT_W-1:0]  cnt_q;
  logic                over_q;

  logic [COUNT_W-1:0]  mem_q [Depth];
  logic [COUNT_W-1:0]  ram_rd_q;

  logic                accept;
  logic                fwd;
  logic [COUNT_W-1:0]  old_val;
  logic [COUNT_W-1:0]  amt_ext;
  logic [COUNT_W:0]    sum;
  logic [COUNT_W-1:0]  new_val;
  logic                ram_we;
  logic [CLIENT_W-1:0] ram_waddr;
  logic [COUNT_W-1:0]  ram_wdata;

  assign accept = bus.in_valid && in_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      sweep_q     <= '0;
      in_ready_q  <= 1'b0;
      init_busy_q <= 1'b1;
    end else begin
      unique case (state_q)
        StInit: begin
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == {CLIENT_W{1'b1}}) begin
            state_q     <= StRun;
            in_ready_q  <= 1'b1;
            init_busy_q <= 1'b0;
          end
        end
        StRun: begin
          state_q <= StRun;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OpAdd;
      s1_client_q <= '0;
      s1_amount_q <= '0;
      s1_limit_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_op_q     <= bus.op;
        s1_client_q <= bus.client_id;
        s1_amount_q <= bus.amount;
        s1_limit_q  <= bus.limit;
      end
    end
  end

  // The previous stage-2 result is newer than the RAM when it hit the same client.
  assign fwd     = rd_valid_q && (rd_client_q == s1_client_q);
  assign old_val = fwd ? cnt_q : ram_rd_q;
  assign amt_ext = COUNT_W'(s1_amount_q);
  assign sum     = {1'b0, old_val} + {1'b0, amt_ext};

  always_comb begin
    new_val = old_val;
    unique case (s1_op_q)
      OpAdd:   new_val = sum[COUNT_W] ? {COUNT_W{1'b1}} : sum[COUNT_W-1:0];
      OpSub:   new_val = (old_val < amt_ext) ? '0 : old_val - amt_ext;
      OpClear: new_val = '0;
      OpRead:  new_val = old_val;
    endcase
  end

  // Gating with rst_n keeps the RAM untouched while reset is held.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = s1_client_q;
    ram_wdata = new_val;
    if (state_q == StInit) begin
      ram_we    = rst_n;
      ram_waddr = sweep_q;
      ram_wdata = '0;
    end else if (s1_valid_q && (s1_op_q != OpRead)) begin
      ram_we = rst_n;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[ram_waddr] <= ram_wdata;
    end
    if (accept) begin
      ram_rd_q <= mem_q[bus.client_id];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q  <= 1'b0;
      rd_client_q <= '0;
      cnt_q       <= '0;
      over_q      <= 1'b0;
    end else begin
      rd_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        rd_client_q <= s1_client_q;
        cnt_q       <= new_val;
        over_q      <= (new_val >= s1_limit_q);
      end
    end
  end

  assign bus.in_ready         = in_ready_q;
  assign bus.init_busy        = init_busy_q;
  assign bus.rd_valid         = rd_valid_q;
  assign bus.rd_client        = rd_client_q;
  assign bus.cancelled_orders = cnt_q;
  assign bus.over_limit       = over_q;
endmodule
